instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Sequential PC generator and prefetch buffer for the accelerator command stream; sits directly upstream of
//  instruction_decoder and drives its fetch_instruction/fetch_valid pair. Issues word reads to instruction
//  memory over a valid/ready request channel, buffers in-order responses in a small FIFO, honours back-pressure
//  and PC redirects. Squashes stale in-flight responses after a redirect.
// PARAMETERS
//  ADDR_WIDTH   16  instruction word-address width (PC counts words, +1 per instruction)
//  FIFO_DEPTH   4   prefetch FIFO entries; power of 2, >=2
//  RESET_PC     0   PC loaded on reset
//  MAX_OUTSTAND 4   max requests in flight to imem (<= FIFO_DEPTH)
// PORTS
//  clk               in   1                   clock; one clock domain
//  rst               in   1                   one clock; reset is synchronous and active-high
//  start             in   1                   pulse: leave IDLE, begin fetching at current PC
//  imem_req_valid    out  1                   request valid
//  imem_req_ready    in   1                   memory accepts request when valid&&ready
//  imem_req_addr     out  ADDR_WIDTH          word address of request
//  imem_rsp_valid    in   1                   one response per accepted request, in order, >=1 cycle later
//  imem_rsp_data     in   `INSTRUCTION_WIDTH  instruction word
//  fetch_stall       in   1                   downstream cannot take instruction this cycle
//  redirect_valid    in   1                   pulse: restart fetch at redirect_pc
//  redirect_pc       in   ADDR_WIDTH          new PC
//  fetch_instruction out  `INSTRUCTION_WIDTH  instruction to decoder (registered)
//  fetch_valid       out  1                   fetch_instruction valid
//  fetch_pc          out  ADDR_WIDTH          address of fetch_instruction
//  busy              out  1                   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, FIFO empty, outstanding=0, discard=0; all outputs 0 (imem_req_addr=RESET_PC).
//  FSM (fetch_state_t): IDLE -start-> RUN; RUN -redirect with (outstanding-accepting-rsp)>0-> FLUSH;
//   RUN -redirect, nothing in flight-> RUN; FLUSH -discard reaches 0-> RUN. start ignored outside IDLE.
//  Request: imem_req_valid = (state==RUN) && !redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH
//   && outstanding < MAX_OUTSTAND. On handshake pc <= pc+1 (wraps modulo 2^ADDR_WIDTH), outstanding++.
//   imem_req_addr = pc; addr/valid held stable while valid && !ready.
//  Response: rsp when discard>0 -> dropped, discard--, outstanding--; else pushed to FIFO with its PC
//   (tracked by separate rsp_pc counter), outstanding--. Credit rule guarantees FIFO never overflows.
//  Output stage: register loads FIFO head when (!fetch_valid || !fetch_stall) && FIFO non-empty; fetch_valid
//   cleared when consumed with FIFO empty. While fetch_stall && fetch_valid, outputs hold exactly.
//  Latency: rsp cycle N -> fetch_valid cycle N+2 (FIFO write, then output reg); throughput 1 instr/cycle.
//  Redirect (highest priority, any non-IDLE state): pc<=redirect_pc, rsp_pc<=redirect_pc, FIFO flushed,
//   fetch_valid<=0 next cycle (overrides fetch_stall), discard<=outstanding minus any rsp accepted this cycle;
//   no request issued in redirect cycle. Redirect during FLUSH reloads pc, discard keeps counting down.
//  Redirect in IDLE: loads pc only. Simultaneous redirect+rsp: rsp is discarded. Simultaneous push+pop legal.
//  rst mid-operation: all state cleared next edge; responses arriving afterwards are ignored (IDLE, outstanding=0).
// STRUCTURE
//  instruction_pkg gains: fetch_state_t {FETCH_IDLE, FETCH_RUN, FETCH_FLUSH}, FETCH_ADDR_WIDTH default const,
//   fetch_entry_t {instr, pc}.
//  One sub-module: fetch_fifo (parameterised sync FIFO of fetch_entry_t; push/pop/flush, count, full/empty,
//   sync active-high reset). Counters, FSM, credit logic and output register in top module.
// TESTING
//  1 Reset, start, 1-cycle-latency memory, no stall -> addrs 0,1,2..; fetch_valid continuous, fetch_pc matches.
//  2 Hold fetch_stall 5 cycles -> output unchanged; requests stop once outstanding+count==4; resume, no loss/dup.
//  3 imem_req_ready low 3 cycles -> imem_req_valid/addr held stable; no PC advance.
//  4 3 reqs in flight (latency 4), redirect_pc=0x40 -> FLUSH, 3 rsps dropped, next fetch_pc=0x40, fetch_valid 0 meanwhile.
//  5 pc=0xFFFF streaming -> next addr 0x0000; redirect same cycle as rsp -> rsp dropped.
//  6 Assert rst mid-stream with rsps pending -> outputs 0, IDLE; late rsps never appear at fetch_instruction.

Source files
------------

// File: rtl/instruction_pkg.sv
// Shared instruction-stream types: instruction width, fetch FSM states and
// the prefetch FIFO entry (instruction word plus the PC it was fetched from).
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

package instruction_pkg;

  localparam int INSTR_WIDTH      = `INSTRUCTION_WIDTH;
  localparam int FETCH_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]      instr;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Synchronous prefetch FIFO of fetch entries. Flush empties it in one cycle;
// pushes into a full FIFO and pops from an empty one are ignored.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module fetch_fifo
  import instruction_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           rd_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW:0]     count_r;
  logic            push_s;
  logic            pop_s;

  assign full     = (count_r == CNT_FULL);
  assign empty    = (count_r == CNT_ZERO);
  assign count    = count_r;
  assign rd_entry = mem_r[rd_ptr_r];
  assign push_s   = push && !full && !flush;
  assign pop_s    = pop && !empty && !flush;

  // Entry storage: data only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_entry;
    end
  end

  // Pointer and occupancy bookkeeping; flush behaves like a reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential PC generator with prefetch buffer feeding instruction_decoder.
// Issues word reads over a valid/ready channel, keeps requests-in-flight plus
// buffered words within the FIFO depth, and squashes responses that were in
// flight when a redirect arrived.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module instruction_fetch_unit
  import instruction_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = FETCH_ADDR_WIDTH,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = {ADDR_WIDTH{1'b0}},
  parameter int                    MAX_OUTSTAND = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [ADDR_WIDTH-1:0]         imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [`INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                          fetch_stall,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic [`INSTRUCTION_WIDTH-1:0] fetch_instruction,
  output logic                          fetch_valid,
  output logic [ADDR_WIDTH-1:0]         fetch_pc,
  output logic                          busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]           DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]         OUT_LIM   = CW'(MAX_OUTSTAND);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [`INSTRUCTION_WIDTH-1:0] INSTR_ZERO = {`INSTRUCTION_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PC_ZERO   = {ADDR_WIDTH{1'b0}};

  fetch_state_t                  state_r;
  fetch_state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]         pc_r;
  logic [ADDR_WIDTH-1:0]         rsp_pc_r;
  logic [CW-1:0]                 outstanding_r;
  logic [CW-1:0]                 outstanding_nxt_s;
  logic [CW-1:0]                 discard_r;
  logic [CW-1:0]                 discard_nxt_s;
  logic [CW-1:0]                 fifo_count_s;
  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  fetch_entry_t                  fifo_wr_s;
  fetch_entry_t                  fifo_head_s;
  logic [CW:0]                   credit_sum_s;
  logic                          redirect_act_s;
  logic                          req_valid_s;
  logic                          req_fire_s;
  logic                          rsp_fire_s;
  logic                          rsp_drop_s;
  logic                          rsp_push_s;
  logic                          load_s;
  logic [`INSTRUCTION_WIDTH-1:0] fetch_instruction_r;
  logic                          fetch_valid_r;
  logic [ADDR_WIDTH-1:0]         fetch_pc_r;

  // Request credit, response classification and output-stage load decision.
  always_comb begin
    redirect_act_s = redirect_valid && (state_r != FETCH_IDLE);
    credit_sum_s   = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    req_valid_s    = (state_r == FETCH_RUN) && !redirect_valid && !fifo_full_s
                     && (credit_sum_s < DEPTH_LIM) && (outstanding_r < OUT_LIM);
    req_fire_s     = req_valid_s && imem_req_ready;
    // Responses only count against requests we still consider in flight,
    // which makes late responses after a reset harmless.
    rsp_fire_s     = imem_rsp_valid && (state_r != FETCH_IDLE) && (outstanding_r != CNT_ZERO);
    rsp_drop_s     = rsp_fire_s && (redirect_act_s || (discard_r != CNT_ZERO));
    rsp_push_s     = rsp_fire_s && !rsp_drop_s;
    load_s         = !redirect_act_s && !fifo_empty_s && (!fetch_valid_r || !fetch_stall);
    fifo_wr_s.instr = imem_rsp_data;
    fifo_wr_s.pc    = FETCH_ADDR_WIDTH'(rsp_pc_r);
  end

  // Next-state logic for in-flight counter, discard counter and FSM.
  always_comb begin
    state_nxt_s       = state_r;
    outstanding_nxt_s = outstanding_r;
    discard_nxt_s     = discard_r;
    case ({req_fire_s, rsp_fire_s})
      2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
      default: outstanding_nxt_s = outstanding_r;
    endcase
    // No request fires in a redirect cycle, so everything still in flight
    // after this cycle's response is stale.
    if (redirect_act_s) begin
      discard_nxt_s = outstanding_nxt_s;
    end else if (rsp_drop_s) begin
      discard_nxt_s = discard_r - CNT_ONE;
    end else begin
      discard_nxt_s = discard_r;
    end
    case (state_r)
      FETCH_IDLE: begin
        if (start) begin
          state_nxt_s = FETCH_RUN;
        end else begin
          state_nxt_s = FETCH_IDLE;
        end
      end
      FETCH_RUN: begin
        if (redirect_act_s && (discard_nxt_s != CNT_ZERO)) begin
          state_nxt_s = FETCH_FLUSH;
        end else begin
          state_nxt_s = FETCH_RUN;
        end
      end
      FETCH_FLUSH: begin
        if (discard_nxt_s == CNT_ZERO) begin
          state_nxt_s = FETCH_RUN;
        end else begin
          state_nxt_s = FETCH_FLUSH;
        end
      end
      default: state_nxt_s = FETCH_IDLE;
    endcase
  end

  // Control state: FSM, request/response PCs and the two counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FETCH_IDLE;
      pc_r          <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
    end else begin
      state_r       <= state_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      if (redirect_valid) begin
        pc_r <= redirect_pc;
      end else if (req_fire_s) begin
        pc_r <= pc_r + PC_ONE;
      end
      // rsp_pc shadows pc while idle so fetching starts in step.
      if (redirect_valid) begin
        rsp_pc_r <= redirect_pc;
      end else if (state_r == FETCH_IDLE) begin
        rsp_pc_r <= pc_r;
      end else if (rsp_push_s) begin
        rsp_pc_r <= rsp_pc_r + PC_ONE;
      end
    end
  end

  // Output register towards the decoder; redirect clears it even when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_instruction_r <= INSTR_ZERO;
      fetch_valid_r       <= 1'b0;
      fetch_pc_r          <= PC_ZERO;
    end else if (redirect_act_s) begin
      fetch_valid_r <= 1'b0;
    end else if (load_s) begin
      fetch_instruction_r <= fifo_head_s.instr;
      fetch_pc_r          <= ADDR_WIDTH'(fifo_head_s.pc);
      fetch_valid_r       <= 1'b1;
    end else if (fetch_valid_r && !fetch_stall) begin
      fetch_valid_r <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_push_s),
    .pop      (load_s),
    .flush    (redirect_act_s),
    .wr_entry (fifo_wr_s),
    .rd_entry (fifo_head_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign imem_req_valid    = req_valid_s;
  assign imem_req_addr     = pc_r;
  assign fetch_instruction = fetch_instruction_r;
  assign fetch_valid       = fetch_valid_r;
  assign fetch_pc          = fetch_pc_r;
  assign busy              = (state_r != FETCH_IDLE);

endmodule
